seq_alu: RTL and testbench

Parametrised, multi-cycle successor to the 16-bit combinational ALU in the datapath execute stage. It performs the same eight operations on WIDTH-bit operands through a start/done handshake. Add, sub, logic, LBU and unsigned add complete in one cycle. Multiply and divide run iteratively, shift-add and restoring respectively, at one bit per cycle. The block lets the pipeline stall on long operations instead of inferring a wide combinational multiplier/divider.

---
 rtl/seq_alu.sv | 164 ++++++++++++++++
 tb/tb_seq_alu.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle add/sub/logic/LBU/unsigned add, iterative
// shift-add multiply and restoring divide at one bit per cycle.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] r,
  output logic             sign_flag,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_LBU  = 3'b110;
  localparam logic [2:0] OP_UADD = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Handshake: start is sampled on a rising edge whenever busy=0 (IDLE or
  // DONE); the result is presented with done=1 for one cycle and held after.
  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             accept, is_long;

  logic [WIDTH-1:0] sc_out, sc_r;
  logic             sc_sign, sc_dbz;
  logic [WIDTH:0]   wide_sum;

  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] hi_next, lo_next;

  assign accept  = start && (state != RUN);
  assign is_long = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));

  always_comb begin
    sc_out   = '0;
    sc_r     = '0;
    sc_sign  = 1'b0;
    sc_dbz   = 1'b0;
    wide_sum = '0;
    case (op)
      OP_ADD: begin
        wide_sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        sc_out   = wide_sum[WIDTH-1:0];
        sc_sign  = wide_sum[WIDTH];
      end
      OP_SUB: begin
        wide_sum = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        sc_out   = wide_sum[WIDTH-1:0];
        sc_sign  = wide_sum[WIDTH];
      end
      OP_DIV: begin
        // Only the b=0 case completes in one cycle.
        sc_out = '1;
        sc_r   = a;
        sc_dbz = 1'b1;
      end
      OP_AND: sc_out = a & b;
      OP_OR:  sc_out = a | b;
      OP_LBU: sc_out = WIDTH'(a[7:0]);
      OP_UADD: begin
        wide_sum = {1'b0, a} + {1'b0, b};
        sc_out   = wide_sum[WIDTH-1:0];
        sc_r     = WIDTH'(wide_sum[WIDTH]);
      end
      default: ;
    endcase
  end

  // Remainder stays below the divisor, so the shifted value is below twice
  // the divisor and bit WIDTH of the difference is exactly the borrow.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ge    = !div_diff[WIDTH];
    if (is_div) begin
      hi_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      lo_next = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = is_long ? RUN : DONE;
      RUN: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = is_long ? RUN : DONE;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      is_div      <= 1'b0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
      out         <= '0;
      r           <= '0;
      sign_flag   <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (is_long) begin
        cnt    <= CW'(WIDTH);
        is_div <= op[0];
        acc_hi <= '0;
        acc_lo <= (op == OP_MUL) ? b : a;
        opnd   <= (op == OP_MUL) ? a : b;
      end else begin
        out         <= sc_out;
        r           <= sc_r;
        sign_flag   <= sc_sign;
        div_by_zero <= sc_dbz;
      end
    end else if (state == RUN) begin
      cnt    <= cnt - CW'(1);
      acc_hi <= hi_next;
      acc_lo <= lo_next;
      if (cnt == CW'(1)) begin
        out         <= lo_next;
        r           <= hi_next;
        sign_flag   <= 1'b0;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: reference model feeds an expected-result
// queue that is popped on each done pulse.
module tb_seq_alu;

  localparam int W  = 16;
  localparam int RW = 2 * W + 2;

  logic         clk, rst, start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] out, r;
  logic         sign_flag, div_by_zero;

  logic [RW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .out(out), .r(r),
    .sign_flag(sign_flag), .div_by_zero(div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected {out, r, sign_flag, div_by_zero}
  function automatic logic [RW-1:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    logic [W-1:0]   eo, er;
    logic           s, z;
    longint         sx, sy, sum;
    logic [63:0]    sv;
    logic [2*W-1:0] p;
    eo = '0; er = '0; s = 1'b0; z = 1'b0;
    sx = x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
    sy = y[W-1] ? longint'(y) - (longint'(1) << W) : longint'(y);
    case (o)
      3'd0, 3'd1: begin
        sum = (o == 3'd0) ? sx + sy : sx - sy;
        sv  = sum;
        eo  = sv[W-1:0];
        s   = (sum < 0);
      end
      3'd2: begin
        p  = (2*W)'(x) * (2*W)'(y);
        eo = p[W-1:0];
        er = p[2*W-1:W];
      end
      3'd3: begin
        if (y == '0) begin eo = '1; er = x; z = 1'b1; end
        else begin eo = x / y; er = x % y; end
      end
      3'd4: eo = x & y;
      3'd5: eo = x | y;
      3'd6: eo[7:0] = x[7:0];
      default: begin
        sv    = longint'(x) + longint'(y);
        eo    = sv[W-1:0];
        er[0] = sv[W];
      end
    endcase
    return {eo, er, s, z};
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    exp_q.push_back(model(o, x, y));
    step(1);
    start = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 4 * W) begin step(1); cyc++; end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, out, r, sign_flag, div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b out=%h r=%h sf=%b dbz=%b, required all 0",
               busy, done, out, r, sign_flag, div_by_zero);
    end
    rst = 1'b0;
    step(2);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_add_sub;
    logic [2:0]   to[6] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1};
    logic [W-1:0] ta[6] = '{16'h0002, 16'h7FFF, 16'h8000, 16'h0005, 16'h8000, 16'h7FFF};
    logic [W-1:0] tb[6] = '{16'hFFFC, 16'h0001, 16'hFFFF, 16'h0007, 16'h0001, 16'hFFFF};
    logic [2:0] o; logic [W-1:0] x, y; logic [RW-1:0] e, g; int cyc;
    for (int i = 0; i < 12; i++) begin
      if (i < 6) begin o = to[i]; x = ta[i]; y = tb[i]; end
      else begin o = 3'($urandom_range(0, 1)); x = W'($urandom); y = W'($urandom); end
      send(o, x, y);
      wait_done(cyc);
      g = {out, r, sign_flag, div_by_zero};
      e = exp_q.pop_front();
      n_checks++;
      if (!done || cyc != 0 || g !== e) begin
        n_fail++;
        $display("FAIL add_sub[%0d] op=%0d: done=%b lat=%0d got=%h, required done=1 lat=1 %h",
                 i, o, done, cyc + 1, g, e);
      end
    end
    step(1);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL add_sub_pulse: done=%b, required 0", done);
    end
  endtask

  task automatic test_logic;
    logic [2:0]   to[5] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
    logic [W-1:0] ta[5] = '{16'h00FF, 16'd10, 16'h1234, 16'hFFFF, 16'h8000};
    logic [W-1:0] tb[5] = '{16'h000F, 16'd5, 16'hABCD, 16'h0002, 16'h7FFF};
    logic [2:0] o; logic [W-1:0] x, y; logic [RW-1:0] e, g; int cyc;
    for (int i = 0; i < 13; i++) begin
      if (i < 5) begin o = to[i]; x = ta[i]; y = tb[i]; end
      else begin o = 3'($urandom_range(4, 7)); x = W'($urandom); y = W'($urandom); end
      send(o, x, y);
      wait_done(cyc);
      g = {out, r, sign_flag, div_by_zero};
      e = exp_q.pop_front();
      n_checks++;
      if (!done || cyc != 0 || g !== e) begin
        n_fail++;
        $display("FAIL logic[%0d] op=%0d: done=%b lat=%0d got=%h, required done=1 lat=1 %h",
                 i, o, done, cyc + 1, g, e);
      end
      step(1);
    end
  endtask

  task automatic test_mul;
    logic [W-1:0] ta[3] = '{16'hFFFF, 16'd5, 16'h0000};
    logic [W-1:0] tb[3] = '{16'hFFFF, 16'd8, 16'h1234};
    logic [W-1:0] x, y; logic [RW-1:0] e, g; int bc;
    for (int i = 0; i < 7; i++) begin
      if (i < 3) begin x = ta[i]; y = tb[i]; end
      else begin x = W'($urandom); y = W'($urandom); end
      send(3'd2, x, y);
      bc = 0;
      while (busy && bc < 4 * W) begin
        if (done) break;
        bc++; step(1);
      end
      g = {out, r, sign_flag, div_by_zero};
      e = exp_q.pop_front();
      n_checks++;
      if (!done || busy || bc != W || g !== e) begin
        n_fail++;
        $display("FAIL mul[%0d] %h*%h: done=%b busy_cycles=%0d got=%h, required done=1 busy_cycles=%0d %h",
                 i, x, y, done, bc, g, W, e);
      end
    end
    step(1);
  endtask

  task automatic test_div;
    logic [W-1:0] ta[5] = '{16'd13, 16'd10, 16'hFFFF, 16'd7, 16'd0};
    logic [W-1:0] tb[5] = '{16'd3, 16'd0, 16'h0001, 16'd9, 16'd5};
    logic [W-1:0] x, y; logic [RW-1:0] e, g; int cyc, lat;
    for (int i = 0; i < 10; i++) begin
      if (i < 5) begin x = ta[i]; y = tb[i]; end
      else begin
        x = W'($urandom);
        y = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 300));
      end
      lat = (y == '0) ? 0 : W;
      send(3'd3, x, y);
      wait_done(cyc);
      g = {out, r, sign_flag, div_by_zero};
      e = exp_q.pop_front();
      n_checks++;
      if (!done || cyc != lat || g !== e) begin
        n_fail++;
        $display("FAIL div[%0d] %h/%h: done=%b lat=%0d got=%h, required done=1 lat=%0d %h",
                 i, x, y, done, cyc + 1, g, lat + 1, e);
      end
      step(1);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] to[7] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [W-1:0] x, y; logic [RW-1:0] e, g;
    for (int i = 0; i < 7; i++) begin
      x = W'($urandom);
      y = (to[i] == 3'd3) ? '0 : W'($urandom);
      start = 1'b1; op = to[i]; a = x; b = y;
      exp_q.push_back(model(to[i], x, y));
      step(1);
      g = {out, r, sign_flag, div_by_zero};
      e = exp_q.pop_front();
      n_checks++;
      if (done !== 1'b1 || g !== e) begin
        n_fail++;
        $display("FAIL back_to_back[%0d] op=%0d: done=%b got=%h, required done=1 %h",
                 i, to[i], done, g, e);
      end
    end
    start = 1'b0;
    step(1);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_end: done=%b, required 0", done);
    end
  endtask

  task automatic test_start_while_busy;
    logic [RW-1:0] e, g; int ndone;
    send(3'd2, 16'h1234, 16'h00AB);
    step(4);
    start = 1'b1; op = 3'd0; a = 16'd1; b = 16'd1;
    step(1);
    start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 3 * W; c++) begin
      if (done) begin
        ndone++;
        g = {out, r, sign_flag, div_by_zero};
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_checks++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL busy_ignore_result: got=%h, required %h", g, e);
        end
      end
      step(1);
    end
    n_checks++;
    if (ndone != 1) begin
      n_fail++;
      $display("FAIL busy_ignore_count: done pulses=%0d, required 1", ndone);
    end
  endtask

  task automatic test_reset_mid_div;
    logic [RW-1:0] e, g; int ndone, cyc;
    send(3'd3, 16'h1234, 16'd7);
    void'(exp_q.pop_back());
    step(7);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, out, r, sign_flag, div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_div: busy=%b done=%b out=%h r=%h sf=%b dbz=%b, required all 0",
               busy, done, out, r, sign_flag, div_by_zero);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 2 * W; c++) begin
      if (done || busy) ndone++;
      step(1);
    end
    n_checks++;
    if (ndone != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: busy/done cycles=%0d, required 0", ndone);
    end
    send(3'd0, 16'd3, 16'd4);
    wait_done(cyc);
    g = {out, r, sign_flag, div_by_zero};
    e = exp_q.pop_front();
    n_checks++;
    if (!done || cyc != 0 || g !== e) begin
      n_fail++;
      $display("FAIL reset_restart: done=%b lat=%0d got=%h, required done=1 lat=1 %h",
               done, cyc + 1, g, e);
    end
    step(1);
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic();
    test_mul();
    test_div();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_div();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
